// File: rtl/ifft_seq_pkg.sv
// Shared types, constants and the config-word builder for the IFFT frame sequencer.
package ifft_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_LOAD   = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_e;

    localparam int FWD_INV_BIT       = 0;
    localparam int CFG_WIDTH_DEFAULT = 8;

    // The core's FWD_INV bit is 1 for forward, so it is the complement of `inverse`.
    function automatic logic [CFG_WIDTH_DEFAULT-1:0] build_cfg_word(input logic inverse);
        logic [CFG_WIDTH_DEFAULT-1:0] word;
        word              = {CFG_WIDTH_DEFAULT{1'b0}};
        word[FWD_INV_BIT] = ~inverse;
        return word;
    endfunction

endpackage

// File: rtl/ifft_frame_sequencer.sv
// Frame controller for the FFT core: one config beat, N samples in with generated
// tlast, N samples out; flags core tlast mismatches and counts completed frames.
module ifft_frame_sequencer
    import ifft_seq_pkg::*;
#(
    parameter int DATAWIDTH = 48,
    parameter int NFFT_LOG2 = 9,
    parameter int CFG_WIDTH = CFG_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 inverse,
    input  logic [DATAWIDTH-1:0] sInData,
    input  logic                 sInValid,
    output logic                 sInReady,
    output logic [CFG_WIDTH-1:0] configData_IFFT,
    output logic                 configValid_IFFT,
    input  logic                 configReady_IFFT,
    output logic [DATAWIDTH-1:0] mIFFTSData,
    output logic                 mIFFTSValid,
    input  logic                 mIFFTSReady,
    output logic                 mIFFTSLast,
    input  logic [DATAWIDTH-1:0] sIFFTMData,
    input  logic                 sIFFTMValid,
    output logic                 sIFFTMReady,
    input  logic                 sIFFTMLast,
    output logic [DATAWIDTH-1:0] mOutData,
    output logic                 mOutValid,
    input  logic                 mOutReady,
    output logic                 mOutLast,
    output logic                 busy,
    output logic                 frameErr,
    output logic [15:0]          framesDone
);

    localparam logic [NFFT_LOG2-1:0] CNT_LAST = {NFFT_LOG2{1'b1}};
    localparam logic [NFFT_LOG2-1:0] CNT_ONE  = NFFT_LOG2'(1);

    seq_state_e           state_q;
    logic [NFFT_LOG2-1:0] in_cnt_q;
    logic [NFFT_LOG2-1:0] out_cnt_q;
    logic                 inv_latched_q;
    logic                 frame_err_q;
    logic [15:0]          frames_done_q;

    logic in_acc_s;
    logic out_acc_s;
    logic in_last_s;
    logic out_last_s;

    assign in_last_s  = (in_cnt_q == CNT_LAST);
    assign out_last_s = (out_cnt_q == CNT_LAST);
    assign in_acc_s   = (state_q == ST_LOAD) && sInValid && mIFFTSReady;
    assign out_acc_s  = (state_q == ST_DRAIN) && sIFFTMValid && mOutReady;

    // Handshakes pass straight through while their phase is active and are gated off otherwise.
    assign mIFFTSData  = sInData;
    assign mIFFTSValid = (state_q == ST_LOAD) && sInValid;
    assign sInReady    = (state_q == ST_LOAD) && mIFFTSReady;
    assign mIFFTSLast  = (state_q == ST_LOAD) && in_last_s;

    assign mOutData    = sIFFTMData;
    assign mOutValid   = (state_q == ST_DRAIN) && sIFFTMValid;
    assign sIFFTMReady = (state_q == ST_DRAIN) && mOutReady;
    assign mOutLast    = (state_q == ST_DRAIN) && out_last_s;

    assign configValid_IFFT = (state_q == ST_CONFIG);
    assign configData_IFFT  = (state_q == ST_CONFIG) ? CFG_WIDTH'(build_cfg_word(inv_latched_q))
                                                     : {CFG_WIDTH{1'b0}};

    assign busy       = (state_q != ST_IDLE);
    assign frameErr   = frame_err_q;
    assign framesDone = frames_done_q;

    // Frame sequencing FSM with its beat counters, frame counter and tlast checker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_cnt_q      <= {NFFT_LOG2{1'b0}};
            out_cnt_q     <= {NFFT_LOG2{1'b0}};
            inv_latched_q <= 1'b1;
            frame_err_q   <= 1'b0;
            frames_done_q <= 16'd0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        inv_latched_q <= inverse;
                        state_q       <= ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    if (configReady_IFFT) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_acc_s) begin
                        if (in_last_s) begin
                            in_cnt_q <= {NFFT_LOG2{1'b0}};
                            state_q  <= ST_DRAIN;
                        end else begin
                            in_cnt_q <= in_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Our counter ends the frame; the core's tlast is only checked against it.
                    if (out_acc_s) begin
                        frame_err_q <= sIFFTMLast ^ out_last_s;
                        if (out_last_s) begin
                            out_cnt_q     <= {NFFT_LOG2{1'b0}};
                            frames_done_q <= frames_done_q + 16'd1;
                            if (enable) begin
                                inv_latched_q <= inverse;
                                state_q       <= ST_CONFIG;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            out_cnt_q <= out_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_frame_sequencer.sv
// Bench for ifft_frame_sequencer with N=8: a frame-level model plus upstream, core and
// downstream stand-ins, compared every cycle, and directed scenarios with literal checks.
module tb_ifft_frame_sequencer;

    localparam int          DW = 48;
    localparam int          N  = 8;
    localparam logic [47:0] XK = 48'h0000_FFFF_0F0F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          inverse = 1'b1;
    logic [DW-1:0] sInData = '0;
    logic          sInValid = 1'b0;
    logic          sInReady;
    logic [7:0]    configData_IFFT;
    logic          configValid_IFFT;
    logic          configReady_IFFT = 1'b0;
    logic [DW-1:0] mIFFTSData;
    logic          mIFFTSValid;
    logic          mIFFTSReady = 1'b0;
    logic          mIFFTSLast;
    logic [DW-1:0] sIFFTMData = '0;
    logic          sIFFTMValid = 1'b0;
    logic          sIFFTMReady;
    logic          sIFFTMLast = 1'b0;
    logic [DW-1:0] mOutData;
    logic          mOutValid;
    logic          mOutReady = 1'b0;
    logic          mOutLast;
    logic          busy;
    logic          frameErr;
    logic [15:0]   framesDone;

    ifft_frame_sequencer #(.DATAWIDTH(DW), .NFFT_LOG2(3), .CFG_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .inverse(inverse),
        .sInData(sInData), .sInValid(sInValid), .sInReady(sInReady),
        .configData_IFFT(configData_IFFT), .configValid_IFFT(configValid_IFFT),
        .configReady_IFFT(configReady_IFFT),
        .mIFFTSData(mIFFTSData), .mIFFTSValid(mIFFTSValid), .mIFFTSReady(mIFFTSReady),
        .mIFFTSLast(mIFFTSLast),
        .sIFFTMData(sIFFTMData), .sIFFTMValid(sIFFTMValid), .sIFFTMReady(sIFFTMReady),
        .sIFFTMLast(sIFFTMLast),
        .mOutData(mOutData), .mOutValid(mOutValid), .mOutReady(mOutReady), .mOutLast(mOutLast),
        .busy(busy), .frameErr(frameErr), .framesDone(framesDone)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Frame-level model: phase 0 idle, 1 config, 2 load, 3 drain.
    int m_phase = 0;
    int m_ld = 0;
    int m_dr = 0;
    int m_frames = 0;
    bit m_inv = 1'b1;
    bit m_err = 1'b0;
    logic [DW-1:0] exp_q[$];

    // Stand-ins for upstream source, core and downstream, plus bench statistics.
    logic [DW-1:0] core_q[$];
    int  core_idx = 0;
    int  extra_last = -1;
    int  src_cnt = 0;
    int  cfg_seen = 0;
    bit  src_en = 1'b1;
    bit  bp = 1'b0;
    int  cfg_beats = 0;
    logic [7:0] cfg_last = 8'hxx;
    int  err_pulses = 0;
    int  out_beats = 0;

    always @(negedge clk) begin
        chk("busy", busy, m_phase != 0);
        chk("cfg_valid", configValid_IFFT, m_phase == 1);
        chk("cfg_data", configData_IFFT, (m_phase == 1 && !m_inv) ? 64'd1 : 64'd0);
        chk("in_ready", sInReady, m_phase == 2 && mIFFTSReady);
        chk("core_in_valid", mIFFTSValid, m_phase == 2 && sInValid);
        chk("core_in_last", mIFFTSLast, m_phase == 2 && m_ld == N - 1);
        if (m_phase == 2) chk("core_in_data", mIFFTSData, sInData);
        chk("out_valid", mOutValid, m_phase == 3 && sIFFTMValid);
        chk("core_out_ready", sIFFTMReady, m_phase == 3 && mOutReady);
        chk("out_last", mOutLast, m_phase == 3 && m_dr == N - 1);
        chk("frame_err", frameErr, m_err);
        chk("frames_done", framesDone, 64'(m_frames));
        if (m_phase == 3 && sIFFTMValid && mOutReady) begin
            if (exp_q.size() == 0) chk("out_data_avail", 64'd0, 64'd1);
            else chk("out_data", mOutData, exp_q[0]);
        end

        if (configValid_IFFT) cfg_last = configData_IFFT;
        if (frameErr) err_pulses++;

        if (rst) begin
            m_phase = 0; m_ld = 0; m_dr = 0; m_frames = 0; m_inv = 1'b1; m_err = 1'b0;
            exp_q.delete(); core_q.delete(); core_idx = 0; cfg_seen = 0;
        end else begin
            m_err = 1'b0;
            case (m_phase)
                0: if (enable) begin m_inv = inverse; m_phase = 1; end
                1: if (configReady_IFFT) m_phase = 2;
                2: if (sInValid && mIFFTSReady) begin
                       exp_q.push_back(sInData ^ XK);
                       m_ld++;
                       if (m_ld == N) begin m_ld = 0; m_phase = 3; end
                   end
                default: if (sIFFTMValid && mOutReady) begin
                       if (exp_q.size() > 0) void'(exp_q.pop_front());
                       m_err = sIFFTMLast != (m_dr == N - 1);
                       m_dr++;
                       if (m_dr == N) begin
                           m_dr = 0;
                           m_frames = (m_frames + 1) % 65536;
                           if (enable) begin m_inv = inverse; m_phase = 1; end
                           else m_phase = 0;
                       end
                   end
            endcase

            if (sInValid && sInReady) src_cnt++;
            if (mIFFTSValid && mIFFTSReady) core_q.push_back(mIFFTSData);
            if (sIFFTMValid && sIFFTMReady && core_q.size() > 0) begin
                void'(core_q.pop_front());
                core_idx = (core_idx == N - 1) ? 0 : core_idx + 1;
            end
            if (mOutValid && mOutReady) out_beats++;
            if (configValid_IFFT && configReady_IFFT) begin cfg_beats++; cfg_seen = 0; end
            else if (configValid_IFFT) cfg_seen++;
        end
    end

    // Stand-in drivers update just after each rising edge.
    always @(posedge clk) begin
        #1;
        sInValid         = src_en;
        sInData          = {16'hC0DE, 32'(src_cnt)};
        mIFFTSReady      = bp ? ~mIFFTSReady : 1'b1;
        mOutReady        = bp ? ~mOutReady : 1'b1;
        configReady_IFFT = (cfg_seen >= 2);
        sIFFTMValid      = (core_q.size() > 0);
        sIFFTMData       = (core_q.size() > 0) ? (core_q[0] ^ XK) : '0;
        sIFFTMLast       = (core_q.size() > 0) && (core_idx == N - 1 || core_idx == extra_last);
    end

    task automatic wait_for(input int sel, input int target, input string nm);
        bit hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(posedge clk);
            case (sel)
                0:       hit = (m_frames == target);
                1:       hit = (m_phase == target);
                2:       hit = (m_phase == 2 && m_ld == target);
                default: hit = (m_phase == 3 && m_dr == target);
            endcase
        end
        chk({nm, "_timeout"}, 64'(hit), 64'd1);
    endtask

    int base_cfg;
    int base_err;
    int base_out;

    initial begin
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 64'd0);
        chk("rst_frames", framesDone, 64'd0);
        chk("rst_cfg_valid", configValid_IFFT, 64'd0);
        chk("rst_cfg_data", configData_IFFT, 64'd0);
        chk("rst_in_ready", sInReady, 64'd0);
        chk("rst_core_valid", mIFFTSValid, 64'd0);
        chk("rst_core_last", mIFFTSLast, 64'd0);
        chk("rst_out_valid", mOutValid, 64'd0);
        chk("rst_out_last", mOutLast, 64'd0);
        chk("rst_core_ready", sIFFTMReady, 64'd0);
        chk("rst_frame_err", frameErr, 64'd0);
        rst = 1'b0;

        // Inverse frame, no backpressure.
        base_err = err_pulses; base_out = out_beats;
        @(posedge clk); #1;
        inverse = 1'b1; enable = 1'b1;
        wait_for(1, 1, "inv_cfg");
        #1 enable = 1'b0;
        wait_for(0, 1, "inv_frame");
        wait_for(1, 0, "inv_idle");
        #2;
        chk("inv_cfg_word", 64'(cfg_last), 64'h00);
        chk("inv_frames", framesDone, 64'd1);
        chk("inv_no_err", 64'(err_pulses - base_err), 64'd0);
        chk("inv_out_beats", 64'(out_beats - base_out), 64'd8);

        // Forward frame with readies toggling every cycle.
        base_out = out_beats;
        bp = 1'b1; inverse = 1'b0; enable = 1'b1;
        wait_for(1, 2, "fwd_load");
        #1 enable = 1'b0; inverse = 1'b1;
        wait_for(0, 2, "fwd_frame");
        wait_for(1, 0, "fwd_idle");
        #2;
        chk("fwd_cfg_word", 64'(cfg_last), 64'h01);
        chk("fwd_frames", framesDone, 64'd2);
        chk("fwd_out_beats", 64'(out_beats - base_out), 64'd8);
        bp = 1'b0;

        // Core raises tlast early on output beat 6 as well as on beat 8.
        base_err = err_pulses;
        extra_last = 5; inverse = 1'b1; enable = 1'b1;
        wait_for(1, 1, "err_cfg");
        #1 enable = 1'b0;
        wait_for(0, 3, "err_frame");
        wait_for(1, 0, "err_idle");
        #2;
        chk("err_pulse_count", 64'(err_pulses - base_err), 64'd1);
        chk("err_frames", framesDone, 64'd3);
        extra_last = -1;

        // Enable dropped during load beat 3.
        base_cfg = cfg_beats;
        enable = 1'b1;
        wait_for(2, 2, "drop_load");
        #1 enable = 1'b0;
        wait_for(0, 4, "drop_frame");
        repeat (5) @(posedge clk);
        #2;
        chk("drop_busy", busy, 64'd0);
        chk("drop_frames", framesDone, 64'd4);
        chk("drop_cfg_beats", 64'(cfg_beats - base_cfg), 64'd1);

        // Reset during drain beat 4, then a fresh frame.
        inverse = 1'b0; enable = 1'b1;
        wait_for(3, 3, "rst_drain");
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 64'd0);
        chk("midrst_frames", framesDone, 64'd0);
        base_cfg = cfg_beats;
        wait_for(1, 2, "rerun_load");
        #1 enable = 1'b0;
        wait_for(0, 1, "rerun_frame");
        wait_for(1, 0, "rerun_idle");
        #2;
        chk("rerun_frames", framesDone, 64'd1);
        chk("rerun_cfg_beats", 64'(cfg_beats - base_cfg), 64'd1);
        chk("rerun_cfg_word", 64'(cfg_last), 64'h01);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
